// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HELD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INIT_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem reads and fills the IF/ID latch, with a
// one-entry hold buffer that keeps an instruction returned while decode is stalled.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = WORD_W'(PC_INIT_DEF)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] instro,
  output logic [WORD_W-1:0] pco,
  output logic [WORD_W-1:0] pcplus4o,
  output logic              valido
);

  fetch_state_t      state, next_state;
  logic [WORD_W-1:0] pc, next_pc;
  logic [WORD_W-1:0] pc_plus4;

  logic [WORD_W-1:0] ifid_instr, next_ifid_instr;
  logic [WORD_W-1:0] ifid_pc, next_ifid_pc;
  logic [WORD_W-1:0] ifid_pc4, next_ifid_pc4;
  logic              ifid_valid, next_ifid_valid;

  logic [WORD_W-1:0] hold_instr, next_hold_instr;
  logic [WORD_W-1:0] hold_pc, next_hold_pc;
  logic [WORD_W-1:0] hold_pc4, next_hold_pc4;

  logic              fetch_done;

  assign pc_plus4   = pc + WORD_W'(4);
  assign fetch_done = (state == FETCH) && ihit;

  assign imemREN  = (state == FETCH);
  assign imemaddr = pc;
  assign instro   = ifid_instr;
  assign pco      = ifid_pc;
  assign pcplus4o = ifid_pc4;
  assign valido   = ifid_valid;

  always_comb begin
    next_state      = state;
    next_pc         = pc;
    next_ifid_instr = ifid_instr;
    next_ifid_pc    = ifid_pc;
    next_ifid_pc4   = ifid_pc4;
    next_ifid_valid = ifid_valid;
    next_hold_instr = hold_instr;
    next_hold_pc    = hold_pc;
    next_hold_pc4   = hold_pc4;

    if (state == HALTED) begin
      next_ifid_valid = 1'b0;
    end else if (halt) begin
      next_state      = HALTED;
      next_ifid_valid = 1'b0;
    end else if (redirect_en || flush) begin
      // Leaving for FETCH discards the hold buffer; a completed fetch still
      // advances pc when there is no explicit target.
      next_state = FETCH;
      if (redirect_en) begin
        next_pc = redirect_addr;
      end else if (fetch_done) begin
        next_pc = pc_plus4;
      end
      if (flush) begin
        next_ifid_instr = '0;
        next_ifid_pc    = '0;
        next_ifid_pc4   = '0;
        next_ifid_valid = 1'b0;
      end else if (!stall) begin
        next_ifid_valid = 1'b0;
      end
    end else if (stall) begin
      if (fetch_done) begin
        next_hold_instr = imemload;
        next_hold_pc    = pc;
        next_hold_pc4   = pc_plus4;
        next_pc         = pc_plus4;
        next_state      = HELD;
      end
    end else if (state == HELD) begin
      next_ifid_instr = hold_instr;
      next_ifid_pc    = hold_pc;
      next_ifid_pc4   = hold_pc4;
      next_ifid_valid = 1'b1;
      next_state      = FETCH;
    end else if (ihit) begin
      next_ifid_instr = imemload;
      next_ifid_pc    = pc;
      next_ifid_pc4   = pc_plus4;
      next_ifid_valid = 1'b1;
      next_pc         = pc_plus4;
    end else begin
      next_ifid_valid = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      ifid_instr <= '0;
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
      hold_pc4   <= '0;
    end else begin
      state      <= next_state;
      pc         <= next_pc;
      ifid_instr <= next_ifid_instr;
      ifid_pc    <= next_ifid_pc;
      ifid_pc4   <= next_ifid_pc4;
      ifid_valid <= next_ifid_valid;
      hold_instr <= next_hold_instr;
      hold_pc    <= next_hold_pc;
      hold_pc4   <= next_hold_pc4;
    end
  end

endmodule
